// File: rtl/wb_dma_copy.sv
// wb_dma_copy
//   Wishbone classic master that copies a block of 32-bit words from a source
//   region to a destination region: one read access then one write access per
//   word, strictly in ascending address order.
//
// Ports
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   start_i                one-cycle request, sampled only while idle
//   abort_i                stop the current transfer after the access in flight
//   src_adr_i, dst_adr_i   byte addresses, forced to word alignment
//   len_i                  number of words to copy
//   busy_o                 transfer in progress (low again in the done_o cycle)
//   done_o                 one-cycle pulse at the end of every transfer
//   err_o                  sticky access-timeout flag, cleared by the next start
//   count_o                words fully written so far
//   wbm_*                  Wishbone classic master port (all outputs registered)
//
// State table
//   state   | meaning
//   ST_IDLE | waiting for start_i
//   ST_RD   | read access to the current source word in flight
//   ST_WR   | write access to the current destination word in flight
//   ST_FIN  | end of transfer: done_o pulse, then back to idle

module wb_dma_copy #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [31:0]      src_adr_i,
  input  logic [31:0]      dst_adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] count_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // The access timer counts down from TIMEOUT-1 so that reaching zero without
  // an ack marks the TIMEOUT-th cycle of strobe.
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [31:0]      r_adr;
  logic [31:0]      r_dat;
  logic             r_we;
  logic             r_cyc;
  logic             r_stb;

  logic [LEN_W-1:0] w_count_inc;
  logic [31:0]      w_src_next;
  logic [31:0]      w_dst_next;
  logic             w_to_expired;
  logic             w_unused;

  assign w_count_inc  = r_count + 1'b1;
  assign w_src_next   = r_src + 32'd4;
  assign w_dst_next   = r_dst + 32'd4;
  assign w_to_expired = (r_to_cnt == '0);
  // Byte-offset bits of the start addresses are deliberately dropped.
  assign w_unused     = ^{src_adr_i[1:0], dst_adr_i[1:0]};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= ST_IDLE;
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_count  <= '0;
      r_to_cnt <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_we     <= 1'b0;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_src   <= {src_adr_i[31:2], 2'b00};
            r_dst   <= {dst_adr_i[31:2], 2'b00};
            r_len   <= len_i;
            r_count <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            if (len_i == '0) begin
              // busy_o stays up for one cycle; ST_FIN then raises done_o.
              r_state <= ST_FIN;
            end else begin
              r_state  <= ST_RD;
              r_cyc    <= 1'b1;
              r_stb    <= 1'b1;
              r_we     <= 1'b0;
              r_adr    <= {src_adr_i[31:2], 2'b00};
              r_to_cnt <= TO_LOAD;
            end
          end
        end

        ST_RD: begin
          if (wbm_ack_i) begin
            r_dat <= wbm_dat_i;
            if (abort_i) begin
              // Word was read but will not be written.
              r_state <= ST_FIN;
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              // stb stays high; the responder's self-clearing ack keeps the
              // read and the following write distinct.
              r_state  <= ST_WR;
              r_we     <= 1'b1;
              r_adr    <= r_dst;
              r_to_cnt <= TO_LOAD;
            end
          end else if (abort_i) begin
            r_state <= ST_FIN;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_to_expired) begin
            r_state <= ST_FIN;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt - 1'b1;
          end
        end

        ST_WR: begin
          if (wbm_ack_i) begin
            r_count <= w_count_inc;
            r_src   <= w_src_next;
            r_dst   <= w_dst_next;
            if (abort_i || (w_count_inc == r_len)) begin
              r_state <= ST_FIN;
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_we    <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state  <= ST_RD;
              r_we     <= 1'b0;
              r_adr    <= w_src_next;
              r_to_cnt <= TO_LOAD;
            end
          end else if (abort_i) begin
            r_state <= ST_FIN;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_to_expired) begin
            r_state <= ST_FIN;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt - 1'b1;
          end
        end

        ST_FIN: begin
          // Entered with busy still high only from a zero-length start; in that
          // case the done pulse is issued here, one cycle later.
          if (r_busy) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign count_o   = r_count;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_sel_o = 4'hF;
  assign wbm_we_o  = r_we;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_stb;

endmodule

// File: tb/tb_wb_dma_copy.sv
module tb_wb_dma_copy;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] len;
  logic        busy, done, err;
  logic [15:0] count;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic        ack;
  logic [31:0] rdat;

  bit   [31:0] mem [0:1023];
  bit          noack;
  logic        pre_we;
  logic [31:0] pre_adr;
  logic [31:0] pre_dat;

  int          ack_n = 0;
  int          log_n = 0;
  logic [31:0] log_adr [0:255];
  logic        log_we  [0:255];
  logic [3:0]  log_sel [0:255];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_dma_copy #(.LEN_W(16), .TIMEOUT(255), .TO_W(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .start_i  (start),
    .abort_i  (abort),
    .src_adr_i(src),
    .dst_adr_i(dst),
    .len_i    (len),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err),
    .count_o  (count),
    .wbm_adr_o(adr),
    .wbm_dat_o(wdat),
    .wbm_sel_o(sel),
    .wbm_we_o (we),
    .wbm_cyc_o(cyc),
    .wbm_stb_o(stb),
    .wbm_dat_i(rdat),
    .wbm_ack_i(ack)
  );

  // One-wait-state RAM responder (ack <= valid & !ack) plus bus monitor.
  always @(posedge clk) begin
    if (pre_we) mem[pre_adr[11:2]] <= pre_dat;
    if (rst) begin
      ack <= 1'b0;
    end else if (cyc && stb && !ack && !noack) begin
      ack <= 1'b1;
      if (we) mem[adr[11:2]] <= wdat;
      else    rdat <= mem[adr[11:2]];
    end else begin
      ack <= 1'b0;
    end
    if (cyc && stb && ack) begin
      ack_n <= ack_n + 1;
      log_adr[log_n % 256] <= adr;
      log_we[log_n % 256]  <= we;
      log_sel[log_n % 256] <= sel;
      log_n <= log_n + 1;
    end
  end

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we  = 1'b1;
    pre_adr = a;
    pre_dat = d;
    @(negedge clk);
    pre_we  = 1'b0;
  endtask

  // Returns at the negedge of cycle 1 (first cycle after the start edge).
  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(negedge clk);
    src   = s;
    dst   = d;
    len   = l;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, input int budget, output int at,
                           output int stb_n, output bit saw_cyc);
    at = -1;
    stb_n = 0;
    saw_cyc = 1'b0;
    for (int c = c0; c <= budget; c++) begin
      if (cyc) saw_cyc = 1'b1;
      if (stb) stb_n++;
      if (done) begin
        at = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests++; if (done !== 1'b0)     begin fails++; $display("FAIL reset_done got %0b want 0", done); end
    tests++; if (err !== 1'b0)      begin fails++; $display("FAIL reset_err got %0b want 0", err); end
    tests++; if (count !== 16'd0)   begin fails++; $display("FAIL reset_count got %0h want 0", count); end
    tests++; if ({cyc, stb, we} !== 3'b000) begin fails++; $display("FAIL reset_bus got %b want 000", {cyc, stb, we}); end
    tests++; if (adr !== 32'd0)     begin fails++; $display("FAIL reset_adr got %h want 0", adr); end
    tests++; if (wdat !== 32'd0)    begin fails++; $display("FAIL reset_dat got %h want 0", wdat); end
    tests++; if (sel !== 4'hF)      begin fails++; $display("FAIL reset_sel got %h want f", sel); end
  endtask

  task automatic test_basic;
    int at, sn, a0;
    bit sc;
    logic [31:0] exp_w [0:3];
    exp_w[0] = 32'h11111111; exp_w[1] = 32'h22222222;
    exp_w[2] = 32'h33333333; exp_w[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) mem_wr(32'h100 + 4 * i, exp_w[i]);
    a0 = ack_n;
    do_start(32'h100, 32'h400, 16'd4);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %0b want 1", busy); end
    wait_done(1, 60, at, sn, sc);
    tests++; if (at != 17)          begin fails++; $display("FAIL basic_done_cycle got %0d want 17", at); end
    tests++; if (count !== 16'd4)   begin fails++; $display("FAIL basic_count got %0d want 4", count); end
    tests++; if (err !== 1'b0)      begin fails++; $display("FAIL basic_err got %0b want 0", err); end
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL basic_busy_at_done got %0b want 0", busy); end
    tests++; if (ack_n - a0 != 8)   begin fails++; $display("FAIL basic_acks got %0d want 8", ack_n - a0); end
    @(negedge clk);
    tests++; if (done !== 1'b0)     begin fails++; $display("FAIL basic_done_width got %0b want 0", done); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (mem[(32'h400 >> 2) + i] !== exp_w[i]) begin
        fails++; $display("FAIL basic_mem%0d got %h want %h", i, mem[(32'h400 >> 2) + i], exp_w[i]);
      end
    end
  endtask

  task automatic test_zero_len;
    int at, sn;
    bit sc;
    do_start(32'h100, 32'h800, 16'd0);
    wait_done(1, 20, at, sn, sc);
    tests++; if (at != 2)         begin fails++; $display("FAIL zero_done_cycle got %0d want 2", at); end
    tests++; if (sc !== 1'b0)     begin fails++; $display("FAIL zero_cyc got %0b want 0", sc); end
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL zero_count got %0d want 0", count); end
  endtask

  task automatic test_align;
    int at, sn, l0;
    bit sc;
    l0 = log_n;
    do_start(32'h103, 32'h402, 16'd1);
    wait_done(1, 30, at, sn, sc);
    tests++; if (at != 5) begin fails++; $display("FAIL align_done_cycle got %0d want 5", at); end
    tests++; if (log_n - l0 != 2) begin fails++; $display("FAIL align_accesses got %0d want 2", log_n - l0); end
    tests++; if (log_adr[l0 % 256] !== 32'h100 || log_we[l0 % 256] !== 1'b0)
      begin fails++; $display("FAIL align_rd got adr %h we %b want 100/0", log_adr[l0 % 256], log_we[l0 % 256]); end
    tests++; if (log_adr[(l0 + 1) % 256] !== 32'h400 || log_we[(l0 + 1) % 256] !== 1'b1)
      begin fails++; $display("FAIL align_wr got adr %h we %b want 400/1", log_adr[(l0 + 1) % 256], log_we[(l0 + 1) % 256]); end
    tests++; if (log_sel[l0 % 256] !== 4'hF || log_sel[(l0 + 1) % 256] !== 4'hF)
      begin fails++; $display("FAIL align_sel got %h/%h want f/f", log_sel[l0 % 256], log_sel[(l0 + 1) % 256]); end
  endtask

  task automatic test_timeout;
    int at, sn;
    bit sc;
    noack = 1'b1;
    do_start(32'h100, 32'h900, 16'd2);
    wait_done(1, 400, at, sn, sc);
    tests++; if (sn != 255)       begin fails++; $display("FAIL timeout_stb_cycles got %0d want 255", sn); end
    tests++; if (at != 256)       begin fails++; $display("FAIL timeout_done_cycle got %0d want 256", at); end
    tests++; if (err !== 1'b1)    begin fails++; $display("FAIL timeout_err got %0b want 1", err); end
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL timeout_count got %0d want 0", count); end
    tests++; if (stb !== 1'b0)    begin fails++; $display("FAIL timeout_stb_drop got %0b want 0", stb); end
    noack = 1'b0;
    do_start(32'h100, 32'h900, 16'd0);
    tests++; if (err !== 1'b0)    begin fails++; $display("FAIL timeout_err_clear got %0b want 0", err); end
    wait_done(1, 20, at, sn, sc);
  endtask

  task automatic test_abort;
    int hit, a0;
    bit sc;
    for (int i = 0; i < 5; i++) mem_wr(32'h200 + 4 * i, 32'hA0000000 + i);
    do_start(32'h200, 32'h600, 16'd5);
    hit = -1;
    for (int c = 1; c <= 40; c++) begin
      if (we && ack && count == 16'd1) begin
        hit = c;
        break;
      end
      @(negedge clk);
    end
    tests++; if (hit != 8) begin fails++; $display("FAIL abort_wr2_ack_cycle got %0d want 8", hit); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++; if (done !== 1'b1)   begin fails++; $display("FAIL abort_done got %0b want 1", done); end
    tests++; if (count !== 16'd2) begin fails++; $display("FAIL abort_count got %0d want 2", count); end
    tests++; if (err !== 1'b0)    begin fails++; $display("FAIL abort_err got %0b want 0", err); end
    a0 = ack_n;
    sc = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (cyc || stb) sc = 1'b1;
      @(negedge clk);
    end
    tests++; if (sc !== 1'b0 || ack_n != a0)
      begin fails++; $display("FAIL abort_quiet got cyc %0b acks %0d want 0/0", sc, ack_n - a0); end
    tests++; if (mem[32'h604 >> 2] !== 32'hA0000001)
      begin fails++; $display("FAIL abort_word2 got %h want a0000001", mem[32'h604 >> 2]); end
    tests++; if (mem[32'h608 >> 2] !== 32'h0)
      begin fails++; $display("FAIL abort_word3 got %h want 0", mem[32'h608 >> 2]); end
  endtask

  task automatic test_reset_busy;
    int at, sn, a0;
    bit sc, sd;
    do_start(32'h100, 32'h500, 16'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if ({cyc, stb, busy, done} !== 4'b0000)
      begin fails++; $display("FAIL rst_mid_rd got cyc/stb/busy/done %b want 0000", {cyc, stb, busy, done}); end
    sd = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (done || cyc) sd = 1'b1;
      @(negedge clk);
    end
    tests++; if (sd !== 1'b0) begin fails++; $display("FAIL rst_no_done got %0b want 0", sd); end
    a0 = ack_n;
    do_start(32'h100, 32'h500, 16'd3);
    @(negedge clk);
    start = 1'b1;
    src   = 32'h300;
    dst   = 32'h700;
    len   = 16'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, 60, at, sn, sc);
    tests++; if (at != 13)        begin fails++; $display("FAIL busy_done_cycle got %0d want 13", at); end
    tests++; if (count !== 16'd3) begin fails++; $display("FAIL busy_count got %0d want 3", count); end
    tests++; if (ack_n - a0 != 6) begin fails++; $display("FAIL busy_acks got %0d want 6", ack_n - a0); end
    tests++; if (mem[32'h500 >> 2] !== 32'h11111111 || mem[32'h504 >> 2] !== 32'h22222222 ||
                 mem[32'h508 >> 2] !== 32'h33333333)
      begin fails++; $display("FAIL busy_mem got %h %h %h want 11111111 22222222 33333333",
                              mem[32'h500 >> 2], mem[32'h504 >> 2], mem[32'h508 >> 2]); end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    src     = '0;
    dst     = '0;
    len     = '0;
    noack   = 1'b0;
    pre_we  = 1'b0;
    pre_adr = '0;
    pre_dat = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_zero_len;
    test_align;
    test_timeout;
    test_abort;
    test_reset_busy;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
